// File: rtl/collision_scheduler.sv
// Bullet-vs-formation collision scheduler: one alien per cycle, at most one kill per fsync.
// Optional score counter enabled by defining COLLISION_SCORE_EN.
module collision_scheduler #(
    parameter int unsigned COLS          = 4,
    parameter int unsigned ROWS          = 2,
    parameter int unsigned H_PITCH       = 32,
    parameter int unsigned V_PITCH       = 24,
    parameter int unsigned ALIEN_W       = 16,
    parameter int unsigned ALIEN_H       = 16,
    parameter int unsigned SCORE_PER_HIT = 10
) (
    input  logic                              pixel_clk,
    input  logic                              rst,
    input  logic                              fsync,
    input  logic                              respawn,
    input  logic                              bullet_active,
    input  logic signed [11:0]                bullet_left,
    input  logic signed [11:0]                bullet_right,
    input  logic signed [11:0]                bullet_top,
    input  logic signed [11:0]                bullet_bottom,
    input  logic signed [11:0]                formation_x,
    input  logic signed [11:0]                formation_y,
    output logic [COLS*ROWS-1:0]              alive_mask,
    output logic                              alien_hit,
    output logic [$clog2(COLS*ROWS)-1:0]      hit_idx,
    output logic                              bullet_kill,
    output logic                              busy,
    output logic                              all_dead,
    output logic [15:0]                       score
);

    localparam int unsigned N     = COLS * ROWS;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [N-1:0]       alive_d;
    logic               hit_d;
    logic [IDX_W-1:0]   hit_idx_d;
    logic               latch_en;

    logic signed [11:0] bl_l_q, bl_r_q, bl_t_q, bl_b_q, fx_q, fy_q;
    logic signed [11:0] lh_c, rh_c, tv_c, bv_c;
    logic               overlap_c;

    assign all_dead = (alive_mask == '0);

    // Box of the alien under evaluation; all arithmetic wraps at 12 bits.
    assign lh_c = fx_q + $signed(12'(col_q * H_PITCH));
    assign rh_c = lh_c + $signed(12'(ALIEN_W - 1));
    assign tv_c = fy_q + $signed(12'(row_q * V_PITCH));
    assign bv_c = tv_c + $signed(12'(ALIEN_H - 1));

    assign overlap_c = (bl_r_q >= lh_c) && (bl_l_q <= rh_c) &&
                       (bl_b_q >= tv_c) && (bl_t_q <= bv_c);

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        col_d     = col_q;
        row_d     = row_q;
        alive_d   = alive_mask;
        hit_d     = 1'b0;
        hit_idx_d = '0;
        latch_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fsync && bullet_active && !all_dead) begin
                    state_d  = SCAN;
                    idx_d    = '0;
                    col_d    = '0;
                    row_d    = '0;
                    latch_en = 1'b1;
                end
            end
            SCAN: begin
                if (overlap_c && alive_mask[idx_q]) begin
                    state_d   = HIT;
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                end else if (idx_q == IDX_W'(N - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (col_q == COL_W'(COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            HIT: begin
                state_d          = IDLE;
                alive_d[hit_idx] = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // respawn overrides any scan result, including a hit found this cycle
        if (respawn) begin
            state_d   = IDLE;
            alive_d   = '1;
            hit_d     = 1'b0;
            hit_idx_d = '0;
            latch_en  = 1'b0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            alive_mask  <= '1;
            alien_hit   <= 1'b0;
            bullet_kill <= 1'b0;
            hit_idx     <= '0;
            busy        <= 1'b0;
            bl_l_q      <= '0;
            bl_r_q      <= '0;
            bl_t_q      <= '0;
            bl_b_q      <= '0;
            fx_q        <= '0;
            fy_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            col_q       <= col_d;
            row_q       <= row_d;
            alive_mask  <= alive_d;
            alien_hit   <= hit_d;
            bullet_kill <= hit_d;
            hit_idx     <= hit_idx_d;
            busy        <= (state_d != IDLE);
            if (latch_en) begin
                bl_l_q <= bullet_left;
                bl_r_q <= bullet_right;
                bl_t_q <= bullet_top;
                bl_b_q <= bullet_bottom;
                fx_q   <= formation_x;
                fy_q   <= formation_y;
            end
        end
    end

`ifdef COLLISION_SCORE_EN
    logic [16:0] score_sum_c;

    assign score_sum_c = {1'b0, score} + 17'(SCORE_PER_HIT);

    // Score advances once per kill, saturating; respawn leaves it untouched.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            score <= '0;
        end else if (state_q == HIT && !respawn) begin
            score <= score_sum_c[16] ? 16'hFFFF : score_sum_c[15:0];
        end
    end
`else
    assign score = 16'h0000;
`endif

endmodule

// File: tb/tb_collision_scheduler.sv
// Randomized self-checking bench for collision_scheduler against a first-overlap reference model.
module tb_collision_scheduler;

    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int H_PITCH = 32;
    localparam int V_PITCH = 24;
    localparam int ALIEN_W = 16;
    localparam int ALIEN_H = 16;
    localparam int SPH = 10;
    localparam int N = COLS * ROWS;
`ifdef COLLISION_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    logic pixel_clk = 1'b0;
    logic rst, fsync, respawn, bullet_active;
    logic signed [11:0] bullet_left, bullet_right, bullet_top, bullet_bottom;
    logic signed [11:0] formation_x, formation_y;
    logic [N-1:0] alive_mask;
    logic alien_hit, bullet_kill, busy, all_dead;
    logic [2:0] hit_idx;
    logic [15:0] score;

    int n_cmp = 0;
    int n_fail = 0;
    logic [N-1:0] m_alive;
    int m_score;

    collision_scheduler #(
        .COLS(COLS), .ROWS(ROWS), .H_PITCH(H_PITCH), .V_PITCH(V_PITCH),
        .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H), .SCORE_PER_HIT(SPH)
    ) dut (
        .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .respawn(respawn),
        .bullet_active(bullet_active),
        .bullet_left(bullet_left), .bullet_right(bullet_right),
        .bullet_top(bullet_top), .bullet_bottom(bullet_bottom),
        .formation_x(formation_x), .formation_y(formation_y),
        .alive_mask(alive_mask), .alien_hit(alien_hit), .hit_idx(hit_idx),
        .bullet_kill(bullet_kill), .busy(busy), .all_dead(all_dead), .score(score)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    // Lowest-index living alien whose box overlaps the bullet, or -1.
    function automatic int model_hit(input logic signed [11:0] l, r, t, b, fx, fy,
                                     input logic [N-1:0] alive);
        logic signed [11:0] lh, rh, tv, bv;
        for (int i = 0; i < N; i++) begin
            lh = 12'(int'(fx) + (i % COLS) * H_PITCH);
            rh = 12'(int'(lh) + ALIEN_W - 1);
            tv = 12'(int'(fy) + (i / COLS) * V_PITCH);
            bv = 12'(int'(tv) + ALIEN_H - 1);
            if (alive[i] && r >= lh && l <= rh && b >= tv && t <= bv) return i;
        end
        return -1;
    endfunction

    task automatic do_respawn();
        respawn = 1'b1;
        step();
        respawn = 1'b0;
        m_alive = '1;
    endtask

    // One fsync frame, checked cycle by cycle; jitter pokes inputs while the scan runs.
    task automatic run_frame(input logic signed [11:0] l, r, t, b, fx, fy,
                             input bit act, input bit jitter);
        int h, last_busy;
        logic [N-1:0] old_alive, new_alive, ea;
        logic eh, eb;
        logic [2:0] ei;
        h = (act && m_alive != '0) ? model_hit(l, r, t, b, fx, fy, m_alive) : -2;
        last_busy = (h == -2) ? 0 : (h < 0) ? N : h + 2;
        old_alive = m_alive;
        new_alive = m_alive;
        if (h >= 0) new_alive[h] = 1'b0;
        bullet_left = l; bullet_right = r; bullet_top = t; bullet_bottom = b;
        formation_x = fx; formation_y = fy; bullet_active = act; fsync = 1'b1;
        step();
        fsync = 1'b0;
        for (int c = 1; c <= N + 2; c++) begin
            eh = (h >= 0 && c == h + 2);
            ei = eh ? 3'(h) : 3'd0;
            eb = (c <= last_busy);
            ea = (h >= 0 && c >= h + 3) ? new_alive : old_alive;
            n_cmp++; if (busy !== eb) begin n_fail++; $display("FAIL busy c%0d got %b want %b", c, busy, eb); end
            n_cmp++; if (alien_hit !== eh) begin n_fail++; $display("FAIL alien_hit c%0d got %b want %b", c, alien_hit, eh); end
            n_cmp++; if (bullet_kill !== eh) begin n_fail++; $display("FAIL bullet_kill c%0d got %b want %b", c, bullet_kill, eh); end
            n_cmp++; if (hit_idx !== ei) begin n_fail++; $display("FAIL hit_idx c%0d got %0d want %0d", c, hit_idx, ei); end
            n_cmp++; if (alive_mask !== ea) begin n_fail++; $display("FAIL alive_mask c%0d got %h want %h", c, alive_mask, ea); end
            if (jitter && c <= last_busy) begin
                fsync = 1'($urandom);
                bullet_active = 1'($urandom);
                bullet_left = 12'($urandom); bullet_right = 12'($urandom);
                bullet_top = 12'($urandom); bullet_bottom = 12'($urandom);
                formation_x = 12'($urandom); formation_y = 12'($urandom);
            end else begin
                fsync = 1'b0;
            end
            step();
        end
        fsync = 1'b0;
        m_alive = new_alive;
        if (h >= 0 && SCORE_EN) m_score = (m_score + SPH > 65535) ? 65535 : m_score + SPH;
        n_cmp++; if (score !== 16'(m_score)) begin n_fail++; $display("FAIL score got %0d want %0d", score, m_score); end
        n_cmp++; if (all_dead !== (m_alive == '0)) begin n_fail++; $display("FAIL all_dead got %b want %b", all_dead, m_alive == '0); end
    endtask

    task automatic test_reset();
        rst = 1'b1; fsync = 1'b0; respawn = 1'b0; bullet_active = 1'b0;
        bullet_left = '0; bullet_right = '0; bullet_top = '0; bullet_bottom = '0;
        formation_x = 12'sd100; formation_y = 12'sd50;
        repeat (3) step();
        rst = 1'b0;
        m_alive = '1; m_score = 0;
        n_cmp++; if (alive_mask !== 8'hFF) begin n_fail++; $display("FAIL rst_alive got %h want ff", alive_mask); end
        n_cmp++; if (alien_hit !== 1'b0 || bullet_kill !== 1'b0) begin n_fail++; $display("FAIL rst_pulse got %b%b want 00", alien_hit, bullet_kill); end
        n_cmp++; if (hit_idx !== 3'd0) begin n_fail++; $display("FAIL rst_hit_idx got %0d want 0", hit_idx); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (score !== 16'd0) begin n_fail++; $display("FAIL rst_score got %0d want 0", score); end
        n_cmp++; if (all_dead !== 1'b0) begin n_fail++; $display("FAIL rst_all_dead got %b want 0", all_dead); end
    endtask

    task automatic test_single_hit();
        run_frame(12'sd136, 12'sd139, 12'sd74, 12'sd81, 12'sd100, 12'sd50, 1'b1, 1'b0);
        n_cmp++; if (alive_mask !== 8'hDF) begin n_fail++; $display("FAIL single_hit_mask got %h want df", alive_mask); end
        n_cmp++; if (score !== (SCORE_EN ? 16'd10 : 16'd0)) begin n_fail++; $display("FAIL single_hit_score got %0d", score); end
        // same bullet again: alien 5 is gone, full scan with no kill
        run_frame(12'sd136, 12'sd139, 12'sd74, 12'sd81, 12'sd100, 12'sd50, 1'b1, 1'b0);
        n_cmp++; if (alive_mask !== 8'hDF) begin n_fail++; $display("FAIL repeat_mask got %h want df", alive_mask); end
    endtask

    task automatic test_edges();
        do_respawn();
        run_frame(12'sd90, 12'sd100, 12'sd40, 12'sd50, 12'sd100, 12'sd50, 1'b1, 1'b0);
        n_cmp++; if (alive_mask !== 8'hFE) begin n_fail++; $display("FAIL edge_touch_mask got %h want fe", alive_mask); end
        run_frame(12'sd148, 12'sd150, 12'sd50, 12'sd60, 12'sd100, 12'sd50, 1'b1, 1'b0);
        n_cmp++; if (alive_mask !== 8'hFE) begin n_fail++; $display("FAIL gap_mask got %h want fe", alive_mask); end
    endtask

    task automatic test_multi_overlap();
        do_respawn();
        run_frame(12'sd140, 12'sd170, 12'sd55, 12'sd60, 12'sd100, 12'sd50, 1'b1, 1'b1);
        n_cmp++; if (alive_mask !== 8'hFD) begin n_fail++; $display("FAIL multi_mask got %h want fd", alive_mask); end
    endtask

    task automatic test_respawn_abort(input int rc);
        logic eb;
        do_respawn();
        bullet_left = 12'sd136; bullet_right = 12'sd139; bullet_top = 12'sd74; bullet_bottom = 12'sd81;
        formation_x = 12'sd100; formation_y = 12'sd50; bullet_active = 1'b1; fsync = 1'b1;
        step();
        fsync = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            eb = (c <= rc);
            n_cmp++; if (alien_hit !== 1'b0 || bullet_kill !== 1'b0) begin n_fail++; $display("FAIL respawn%0d_pulse c%0d got %b%b want 00", rc, c, alien_hit, bullet_kill); end
            n_cmp++; if (busy !== eb) begin n_fail++; $display("FAIL respawn%0d_busy c%0d got %b want %b", rc, c, busy, eb); end
            respawn = (c == rc);
            step();
        end
        respawn = 1'b0;
        n_cmp++; if (alive_mask !== 8'hFF) begin n_fail++; $display("FAIL respawn%0d_mask got %h want ff", rc, alive_mask); end
        n_cmp++; if (score !== 16'(m_score)) begin n_fail++; $display("FAIL respawn%0d_score got %0d want %0d", rc, score, m_score); end
    endtask

    task automatic test_no_bullet();
        run_frame(12'sd136, 12'sd139, 12'sd74, 12'sd81, 12'sd100, 12'sd50, 1'b0, 1'b0);
    endtask

    task automatic test_rst_mid_scan();
        logic eb;
        do_respawn();
        bullet_left = 12'sd136; bullet_right = 12'sd139; bullet_top = 12'sd74; bullet_bottom = 12'sd81;
        formation_x = 12'sd100; formation_y = 12'sd50; bullet_active = 1'b1; fsync = 1'b1;
        step();
        fsync = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            eb = (c <= 3);
            n_cmp++; if (alien_hit !== 1'b0 || bullet_kill !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulse c%0d got %b%b want 00", c, alien_hit, bullet_kill); end
            n_cmp++; if (busy !== eb) begin n_fail++; $display("FAIL rst_mid_busy c%0d got %b want %b", c, busy, eb); end
            rst = (c == 3);
            step();
        end
        rst = 1'b0;
        m_alive = '1; m_score = 0;
        n_cmp++; if (alive_mask !== 8'hFF) begin n_fail++; $display("FAIL rst_mid_mask got %h want ff", alive_mask); end
        n_cmp++; if (score !== 16'd0) begin n_fail++; $display("FAIL rst_mid_score got %0d want 0", score); end
    endtask

    task automatic test_kill_all();
        int lh, tv;
        do_respawn();
        for (int i = 0; i < N; i++) begin
            lh = 100 + (i % COLS) * H_PITCH;
            tv = 50 + (i / COLS) * V_PITCH;
            run_frame(12'(lh + 4), 12'(lh + 8), 12'(tv + 4), 12'(tv + 8), 12'sd100, 12'sd50, 1'b1, 1'b0);
        end
        n_cmp++; if (all_dead !== 1'b1) begin n_fail++; $display("FAIL kill_all_dead got %b want 1", all_dead); end
        n_cmp++; if (score !== (SCORE_EN ? 16'd80 : 16'd0)) begin n_fail++; $display("FAIL kill_all_score got %0d", score); end
        // formation empty: fsync must not start a scan
        run_frame(12'sd100, 12'sd200, 12'sd50, 12'sd100, 12'sd100, 12'sd50, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic signed [11:0] fx, fy, l, t;
        do_respawn();
        for (int k = 0; k < 60; k++) begin
            if (k % 7 == 6) do_respawn();
            fx = 12'($urandom_range(0, 4095));
            fy = 12'($urandom_range(0, 4095));
            l = 12'(int'(fx) + int'($urandom_range(0, 150)) - 10);
            t = 12'(int'(fy) + int'($urandom_range(0, 60)) - 10);
            run_frame(l, 12'(int'(l) + int'($urandom_range(0, 24))),
                      t, 12'(int'(t) + int'($urandom_range(0, 24))),
                      fx, fy, ($urandom_range(0, 7) != 0), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_edges();
        test_multi_overlap();
        test_respawn_abort(4);
        test_respawn_abort(6);
        test_no_bullet();
        test_rst_mid_scan();
        test_kill_all();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_scheduler.md
COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 Parameters (name, default, meaning): COLS 4 formation columns; ROWS 2 formation rows; H_PITCH 32 column pitch in px; V_PITCH 24 row pitch in px; ALIEN_W 16 alien width in px; ALIEN_H 16 alien height in px; SCORE_PER_HIT 10 score increment per kill; N = COLS*ROWS (derived).
REQ-002 pixel_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 fsync  in  1  frame-start pulse; triggers one scan.
REQ-005 respawn  in  1  reload all aliens alive.
REQ-006 bullet_active  in  1  bullet in flight.
REQ-007 bullet_left, bullet_right, bullet_top, bullet_bottom  in  12 each, signed  bullet box, inclusive.
REQ-008 formation_x, formation_y  in  12 each, signed  top-left of alien 0.
REQ-009 alive_mask  out  N  bit i = alien i alive.
REQ-010 alien_hit  out  1  one-cycle kill pulse.
REQ-011 hit_idx  out  clog2(N)  index of killed alien; valid while alien_hit is high.
REQ-012 bullet_kill  out  1  one-cycle pulse, coincident with alien_hit; retires the bullet.
REQ-013 busy  out  1  scan in progress.
REQ-014 all_dead  out  1  alive_mask == 0.
REQ-015 score  out  16  kill score (see Configuration).

Function
REQ-016 States: IDLE, SCAN, HIT; busy = (state != IDLE).
REQ-017 IDLE->SCAN on fsync && bullet_active && !all_dead && !respawn; bullet box and formation_x/y latched that cycle; idx, col, row cleared to 0.
REQ-018 fsync in IDLE with bullet_active=0 or all_dead=1: no scan; stays IDLE.
REQ-019 fsync while in SCAN or HIT: ignored.
REQ-020 SCAN evaluates one alien per cycle, alien idx = row*COLS + col; col/row are tracked as counters, no divider.
REQ-021 Alien box: lh = fx + col*H_PITCH; rh = lh + ALIEN_W - 1; tv = fy + row*V_PITCH; bv = tv + ALIEN_H - 1; all 12-bit signed, wrapping mod 2^12, no saturation.
REQ-022 Overlap: bl_right >= lh && bl_left <= rh && bl_bottom >= tv && bl_top <= bv, all inclusive and signed, using latched values.
REQ-023 In SCAN, overlap with alive_mask[idx]=1: registers hit_idx=idx, moves to HIT; the scan terminates early, and higher indices are not checked this frame.
REQ-024 In SCAN, no qualifying overlap with idx = N-1: go to IDLE. Otherwise idx++, col++, and on col = COLS-1 set col=0 and row++.
REQ-025 HIT lasts exactly one cycle: alien_hit=1, bullet_kill=1, alive_mask[hit_idx] cleared at the end of that cycle; then IDLE.
REQ-026 Latency: with fsync at cycle T, alien i is evaluated at T+1+i; a hit on i asserts alien_hit at T+2+i. A no-hit scan has busy high for cycles T+1..T+N.
REQ-027 At most one kill per fsync.
REQ-028 respawn, any state: alive_mask <= all ones; state <= IDLE; an in-progress scan or pending HIT is aborted with no alien_hit or bullet_kill pulse. respawn has priority over fsync and over a hit in the same cycle.
REQ-029 all_dead is combinational from alive_mask.
REQ-030 alien_hit, bullet_kill, and hit_idx are registered outputs; they are 0 outside HIT.

Reset
REQ-031 rst has priority over all inputs: state=IDLE, alive_mask=all ones, alien_hit=0, bullet_kill=0, hit_idx=0, score=0, internal idx/col/row=0.
REQ-032 rst mid-scan discards the scan; no pulse is emitted on or after the rst cycle.

Configuration
REQ-033 Macro COLLISION_SCORE_EN defined: score increments by SCORE_PER_HIT in each HIT cycle, saturating at 16'hFFFF. respawn does not clear score; only rst does.
REQ-034 Macro COLLISION_SCORE_EN undefined: score is tied to 16'h0000 and no score register exists.

Verification (defaults; formation (100,50))
REQ-035 Bullet L/R/T/B = 136/139/74/81, fsync at cycle 0 -> alien_hit and bullet_kill high at cycle 7 only, hit_idx=5, alive_mask=8'hDF, score=10 (with EN).
REQ-036 Repeat REQ-035 stimulus on the next fsync -> no alien_hit; busy high exactly cycles 1..8; alive_mask stays 8'hDF.
REQ-037 Bullet L/R/T/B = 90/100/40/50, fsync -> edge-touch hit on alien 0 at cycle 2, hit_idx=0. Box 148/150/50/60 -> no hit (the gap between col0 rh=115... col1 lh=132, col1 rh=147 <148).
REQ-038 Bullet overlapping aliens 1 and 2 (L/R/T/B = 140/170/55/60), fsync -> only hit_idx=1; alive_mask=8'hFD.
REQ-039 REQ-035 stimulus with respawn asserted at cycle 4 -> no alien_hit; alive_mask=8'hFF; busy low from cycle 5.
REQ-040 Kill all 8 aliens over successive frames -> all_dead=1, score=80 (0 without EN); the next fsync leaves busy low.
